apb_ctrl_regfile: RTL

//   Parametrised APB4 slave register file for system-control blocks.

---
 rtl/apb_ctrl_regfile.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/apb_ctrl_regfile.sv
// apb_ctrl_regfile
//   APB4 slave register file for system-control blocks. It holds NUM_RW
//   read/write control registers, exposes NUM_RO read-only status inputs, and
//   provides a sticky W1C interrupt-status register with a mask, a VERSION
//   register and a level interrupt output.
//
//   Every transfer takes a fixed 1 + WAIT_CYC cycles from the access phase to
//   pready. Writes, read data and the error flag are all committed on the edge
//   that raises pready.
//
// Ports
//   pclk, preset            clock, synchronous active-high reset
//   psel, penable, pwrite   APB control
//   paddr, pwdata, pstrb    APB address, write data, byte strobes
//   prdata, pready, pslverr APB response (registered)
//   ctrl_o                  packed RW register contents, reg i = ctrl_o[32*i+:32]
//   ro_i                    packed RO status inputs, reg j = ro_i[32*j+:32]
//   irq_evt_i               event pulses that set INT_STATUS bits
//   irq_o                   registered |(INT_STATUS & INT_MASK)
module apb_ctrl_regfile #(
    parameter int                   ADDR_W   = 12,
    parameter int                   NUM_RW   = 4,
    parameter int                   NUM_RO   = 2,
    parameter int                   WAIT_CYC = 0,
    parameter logic [32*NUM_RW-1:0] RW_RST   = {NUM_RW{32'h0}},
    parameter logic [31:0]          VERSION  = 32'h0001_0000
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic [31:0]            pwdata,
    input  logic [3:0]             pstrb,
    output logic [31:0]            prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [32*NUM_RW-1:0]   ctrl_o,
    input  logic [32*NUM_RO-1:0]   ro_i,
    input  logic [31:0]            irq_evt_i,
    output logic                   irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [32*NUM_RW-1:0] ctrl_q, ctrl_d;
    logic [31:0]          status_q, status_d;
    logic [31:0]          mask_q, mask_d;
    logic [31:0]          prdata_q, prdata_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;
    logic                 irq_q, irq_d;

    // ---------------- address decode ----------------
    logic [7:0]  off;
    logic        hi_zero;
    logic        aligned;
    logic        is_rw, is_ro, is_st, is_mk, is_ver;
    logic        err;
    logic [31:0] rd_val;
    logic [31:0] bmask;

    assign off = paddr[7:0];

    if (ADDR_W > 8) begin : g_hi
        assign hi_zero = ~|paddr[ADDR_W-1:8];
    end else begin : g_nohi
        assign hi_zero = 1'b1;
    end

    assign aligned = hi_zero && (off[1:0] == 2'b00);
    assign is_rw   = aligned && !off[7] && (32'(off[6:2]) < NUM_RW);
    assign is_ro   = aligned && (off[7:6] == 2'b10) && (32'(off[5:2]) < NUM_RO);
    assign is_st   = aligned && (off == 8'hC0);
    assign is_mk   = aligned && (off == 8'hC4);
    assign is_ver  = aligned && (off == 8'hFC);

    assign err   = !(is_rw || is_ro || is_st || is_mk || is_ver) ||
                   (pwrite && (is_ro || is_ver));
    assign bmask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};

    always_comb begin
        rd_val = 32'h0;
        for (int i = 0; i < NUM_RW; i++)
            if (is_rw && (off[6:2] == 5'(i))) rd_val = ctrl_q[32*i +: 32];
        for (int j = 0; j < NUM_RO; j++)
            if (is_ro && (off[5:2] == 4'(j))) rd_val = ro_i[32*j +: 32];
        if (is_st)  rd_val = status_q;
        if (is_mk)  rd_val = mask_q;
        if (is_ver) rd_val = VERSION;
    end

    // ---------------- transfer FSM ----------------
    // The IDLE->WAIT edge already counts as the first cycle of latency, so the
    // counter is preloaded with WAIT_CYC-1 and WAIT_CYC=0 commits straight
    // from IDLE. This gives pready exactly 1+WAIT_CYC cycles after penable.
    logic start;
    logic commit;

    assign start  = (state_q == S_IDLE) && psel && penable;
    assign commit = (start && (WAIT_CYC == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (start) begin
                if (WAIT_CYC == 0) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_CYC - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
                else               state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- register updates ----------------
    logic wr_ok;
    assign wr_ok = commit && pwrite && !err;

    always_comb begin
        ctrl_d = ctrl_q;
        for (int i = 0; i < NUM_RW; i++)
            if (wr_ok && is_rw && (off[6:2] == 5'(i)))
                ctrl_d[32*i +: 32] = (ctrl_q[32*i +: 32] & ~bmask) | (pwdata & bmask);

        mask_d = mask_q;
        if (wr_ok && is_mk) mask_d = (mask_q & ~bmask) | (pwdata & bmask);

        // New events are OR-ed in after the clear so a coincident set wins.
        status_d = status_q;
        if (wr_ok && is_st) status_d = status_q & ~(pwdata & bmask);
        status_d = status_d | irq_evt_i;

        pready_d  = commit;
        pslverr_d = commit && err;
        prdata_d  = prdata_q;
        if (commit && !pwrite) prdata_d = err ? 32'h0 : rd_val;

        irq_d = |(status_q & mask_q);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            ctrl_q    <= RW_RST;
            status_q  <= 32'h0;
            mask_q    <= 32'h0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign ctrl_o  = ctrl_q;
    assign irq_o   = irq_q;

endmodule
